// File: rtl/argmax_stream.sv
`default_nettype none
// ============================================================================
//  Module   : argmax_stream
//  Brief    : Streaming argmax over one node row of class scores, emitted with
//             winning class, score and node index over a valid/ready link.
//  Revision : 1.0 - initial release
// ============================================================================
module argmax_stream #(
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int NUM_CLASSES       = 3,
    parameter int LANES             = 1,
    parameter int NUM_NODES         = 6,
    parameter int SIGNED_MODE       = 0,
    parameter int MAX_ADDRESS_WIDTH = $clog2(NUM_CLASSES),
    parameter int NODE_BW           = $clog2(NUM_NODES)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*DOT_PROD_WIDTH-1:0]   in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MAX_ADDRESS_WIDTH-1:0]      out_class,
    output logic [DOT_PROD_WIDTH-1:0]         out_max,
    output logic [NODE_BW-1:0]                out_node,
    output logic                              graph_done
);

    localparam int C_BEATS   = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int C_BEAT_BW = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
    localparam logic [C_BEAT_BW-1:0] C_LAST_BEAT = C_BEAT_BW'(C_BEATS - 1);
    localparam logic [NODE_BW-1:0]   C_LAST_NODE = NODE_BW'(NUM_NODES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic                           r_live;
    logic [C_BEAT_BW-1:0]           r_beat;
    logic [MAX_ADDRESS_WIDTH-1:0]   r_class;
    logic [DOT_PROD_WIDTH-1:0]      r_max;
    logic [NODE_BW-1:0]             r_node;

    logic [DOT_PROD_WIDTH-1:0]      w_lane [LANES];
    logic [DOT_PROD_WIDTH-1:0]      w_beat_max;
    logic [MAX_ADDRESS_WIDTH-1:0]   w_beat_idx;
    logic                           w_accept;
    logic                           w_last_beat;
    logic                           w_out_hs;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_lane[k] = in_data[k*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
        end
    endgenerate

    function automatic logic f_gt(input logic [DOT_PROD_WIDTH-1:0] a,
                                  input logic [DOT_PROD_WIDTH-1:0] b);
        if (SIGNED_MODE != 0)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    // Lane 0 always carries a real class; higher lanes may pad past the last class.
    always_comb begin
        w_beat_max = w_lane[0];
        w_beat_idx = MAX_ADDRESS_WIDTH'(int'(r_beat) * LANES);
        for (int k = 1; k < LANES; k++) begin
            if ((int'(r_beat) * LANES + k < NUM_CLASSES) && f_gt(w_lane[k], w_beat_max)) begin
                w_beat_max = w_lane[k];
                w_beat_idx = MAX_ADDRESS_WIDTH'(int'(r_beat) * LANES + k);
            end
        end
    end

    assign w_accept    = in_valid & in_ready;
    assign w_last_beat = (r_beat == C_LAST_BEAT);
    assign w_out_hs    = (r_state == S_HOLD) & out_ready;

    always_comb begin
        w_state_next = r_state;
        in_ready     = r_live & (r_state != S_HOLD);
        out_valid    = (r_state == S_HOLD);
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = (C_BEATS == 1) ? S_HOLD : S_ACCUM;
            S_ACCUM: if (w_accept && w_last_beat) w_state_next = S_HOLD;
            S_HOLD:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat  <= '0;
            r_class <= '0;
            r_max   <= '0;
            r_node  <= '0;
        end else begin
            if (w_accept) begin
                // Strictly-greater replacement keeps the earlier beat on ties.
                if (r_state == S_IDLE || f_gt(w_beat_max, r_max)) begin
                    r_max   <= w_beat_max;
                    r_class <= w_beat_idx;
                end
                r_beat <= w_last_beat ? '0 : r_beat + C_BEAT_BW'(1);
            end
            if (w_out_hs)
                r_node <= (r_node == C_LAST_NODE) ? '0 : r_node + NODE_BW'(1);
        end
    end

    assign out_class  = r_class;
    assign out_max    = r_max;
    assign out_node   = r_node;
    assign graph_done = w_out_hs & (r_node == C_LAST_NODE);

endmodule
`default_nettype wire

// File: tb/tb_argmax_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_argmax_stream
//  Brief    : Directed scoreboard bench for argmax_stream (unsigned N=3 L=1,
//             signed N=3 L=1, unsigned N=5 L=2 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_stream;

    typedef logic [15:0] row_t [5];
    typedef struct {
        int          cls;
        logic [15:0] mx;
        int          node;
        bit          gd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_gd;
    logic [15:0] a_in_data, a_out_max;
    logic [1:0]  a_out_class;
    logic [2:0]  a_out_node;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_gd;
    logic [15:0] s_in_data, s_out_max;
    logic [1:0]  s_out_class;
    logic [2:0]  s_out_node;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_gd;
    logic [31:0] w_in_data;
    logic [15:0] w_out_max;
    logic [2:0]  w_out_class;
    logic [2:0]  w_out_node;

    argmax_stream u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_class(a_out_class), .out_max(a_out_max), .out_node(a_out_node),
        .graph_done(a_gd)
    );

    argmax_stream #(.SIGNED_MODE(1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_class(s_out_class), .out_max(s_out_max), .out_node(s_out_node),
        .graph_done(s_gd)
    );

    argmax_stream #(.NUM_CLASSES(5), .LANES(2)) u_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_class(w_out_class), .out_max(w_out_max), .out_node(w_out_node),
        .graph_done(w_gd)
    );

    int   errors = 0;
    int   checks = 0;
    int   gd_cnt = 0;
    int   na = 0, ns = 0, nw = 0;
    exp_t qa[$], qs[$], qw[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int which);
        case (which)
            0:       return a_in_ready;
            1:       return s_in_ready;
            default: return w_in_ready;
        endcase
    endfunction

    function automatic logic get_valid(input int which);
        case (which)
            0:       return a_out_valid;
            1:       return s_out_valid;
            default: return w_out_valid;
        endcase
    endfunction

    task automatic set_in(input int which, input logic v, input logic [31:0] d);
        case (which)
            0:       begin a_in_valid = v; a_in_data = d[15:0]; end
            1:       begin s_in_valid = v; s_in_data = d[15:0]; end
            default: begin w_in_valid = v; w_in_data = d; end
        endcase
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic drive_beat(input int which, input logic [31:0] d);
        logic rdy;
        int   n;
        n = 0;
        set_in(which, 1'b1, d);
        forever begin
            @(negedge clk);
            rdy = get_ready(which);
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                check("beat_accept_timeout", 32'(rdy), 1);
                break;
            end
        end
        set_in(which, 1'b0, d);
    endtask

    task automatic send_row(input int which, input row_t s, input int gapmax);
        int          n, l, cls, node, idx, gap;
        bit          sgn, gt;
        logic [15:0] mx, lane;
        logic [31:0] d;
        exp_t        e;
        n   = (which == 2) ? 5 : 3;
        l   = (which == 2) ? 2 : 1;
        sgn = (which == 1);
        cls = 0;
        mx  = s[0];
        for (int i = 1; i < n; i++) begin
            gt = sgn ? ($signed(s[i]) > $signed(mx)) : (s[i] > mx);
            if (gt) begin
                cls = i;
                mx  = s[i];
            end
        end
        case (which)
            0:       begin node = na; na = (na == 5) ? 0 : na + 1; end
            1:       begin node = ns; ns = (ns == 5) ? 0 : ns + 1; end
            default: begin node = nw; nw = (nw == 5) ? 0 : nw + 1; end
        endcase
        e.cls = cls; e.mx = mx; e.node = node; e.gd = (node == 5);
        case (which)
            0:       qa.push_back(e);
            1:       qs.push_back(e);
            default: qw.push_back(e);
        endcase
        for (int b = 0; b < (n + l - 1) / l; b++) begin
            d = '0;
            for (int k = 0; k < l; k++) begin
                idx  = b * l + k;
                lane = (idx < n) ? s[idx] : 16'hFFFF;
                d[k*16 +: 16] = lane;
            end
            gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            drive_beat(which, d);
        end
        @(negedge clk);
        check("latency_out_valid", 32'(get_valid(which)), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((qa.size() + qs.size() + qw.size()) != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_remaining", 32'(qa.size() + qs.size() + qw.size()), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_gd) gd_cnt++;
        if (rst_n && a_out_valid && a_out_ready) begin
            check("a_queue_nonempty", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_class", 32'(a_out_class), e.cls);
                check("a_max", 32'(a_out_max), 32'(e.mx));
                check("a_node", 32'(a_out_node), e.node);
                check("a_graph_done", 32'(a_gd), 32'(e.gd));
            end
        end
        if (rst_n && s_out_valid && s_out_ready) begin
            check("s_queue_nonempty", 32'(qs.size() != 0), 1);
            if (qs.size() != 0) begin
                e = qs.pop_front();
                check("s_class", 32'(s_out_class), e.cls);
                check("s_max", 32'(s_out_max), 32'(e.mx));
                check("s_node", 32'(s_out_node), e.node);
            end
        end
        if (rst_n && w_out_valid && w_out_ready) begin
            check("w_queue_nonempty", 32'(qw.size() != 0), 1);
            if (qw.size() != 0) begin
                e = qw.pop_front();
                check("w_class", 32'(w_out_class), e.cls);
                check("w_max", 32'(w_out_max), 32'(e.mx));
                check("w_node", 32'(w_out_node), e.node);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
        s_in_valid = 0; s_in_data = '0; s_out_ready = 1;
        w_in_valid = 0; w_in_data = '0; w_out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(a_in_ready), 0);
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_out_class", 32'(a_out_class), 0);
        check("rst_out_max", 32'(a_out_max), 0);
        check("rst_out_node", 32'(a_out_node), 0);
        check("rst_graph_done", 32'(a_gd), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_row(0, '{16'd5, 16'd9, 16'd2, 16'd0, 16'd0}, 0);
        send_row(0, '{16'd7, 16'd7, 16'd7, 16'd0, 16'd0}, 0);
        send_row(0, '{16'd3, 16'd8, 16'd8, 16'd0, 16'd0}, 0);
        send_row(0, '{16'hFFFF, 16'h0001, 16'h8000, 16'd0, 16'd0}, 0);

        send_row(1, '{16'hFFFF, 16'h0001, 16'h8000, 16'd0, 16'd0}, 0);
        send_row(1, '{16'h8000, 16'hFFFF, 16'hFFFE, 16'd0, 16'd0}, 0);
        send_row(1, '{16'h7FFF, 16'h8000, 16'h7FFF, 16'd0, 16'd0}, 0);

        send_row(2, '{16'd1, 16'd4, 16'd4, 16'd0, 16'd9}, 0);
        send_row(2, '{16'd7, 16'd3, 16'd7, 16'd9, 16'd9}, 0);
        send_row(2, '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0}, 0);
        wait_drain();

        // Backpressure on node 4.
        a_out_ready = 1'b0;
        send_row(0, '{16'd4, 16'd2, 16'd6, 16'd0, 16'd0}, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(a_out_valid), 1);
            check("bp_in_ready", 32'(a_in_ready), 0);
            check("bp_out_class", 32'(a_out_class), qa[0].cls);
            check("bp_out_max", 32'(a_out_max), 32'(qa[0].mx));
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_released_valid", 32'(a_out_valid), 0);
        check("bp_queue_empty", 32'(qa.size()), 0);
        @(posedge clk);
        #1;

        send_row(0, '{16'd0, 16'd0, 16'd1, 16'd0, 16'd0}, 0);
        send_row(0, '{16'd2, 16'd1, 16'd0, 16'd0, 16'd0}, 0);
        wait_drain();
        check("graph_done_pulses", 32'(gd_cnt), 1);

        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 3; i++) r[i] = 16'($urandom_range(0, 65535));
            r[3] = '0;
            r[4] = '0;
            send_row(0, r, 3);
        end
        wait_drain();

        // Reset after two beats of a row; the partial row must be discarded.
        drive_beat(0, 32'h0000_F000);
        drive_beat(0, 32'h0000_F001);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(a_out_valid), 0);
        check("mid_rst_in_ready", 32'(a_in_ready), 0);
        check("mid_rst_out_node", 32'(a_out_node), 0);
        check("mid_rst_out_max", 32'(a_out_max), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete(); qs.delete(); qw.delete();
        na = 0; ns = 0; nw = 0;
        send_row(0, '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0}, 0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
